input_port_unit: RTL and testbench

Input-side requester for one router input of the 2x4 mesh NoC. It buffers incoming single-flit packets, computes the XY-routed output port for the head flit, and drives that request onto the port's `port_*_dst` input of `switch_allocation_3port` or `switch_allocation_4port`. It watches the allocator's `out_*_sw` selects for its own grant, then presents the granted flit to the crossbar and pops it. One instance sits on each router input: local, X1, X2 and Y.

---
 rtl/input_port_unit_pkg.sv | 33 +++
 rtl/input_port_unit_flit_fifo.sv | 59 +++++
 rtl/input_port_unit.sv | 115 +++++++++++
 tb/tb_input_port_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_unit_pkg.sv
// Shared port/select encodings and XY routing helper for the NoC router
// input side. Port and select codes must match the switch allocators.
package input_port_unit_pkg;

    localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
    localparam logic [2:0] OUT_X1_PORT    = 3'd1;
    localparam logic [2:0] OUT_X2_PORT    = 3'd2;
    localparam logic [2:0] OUT_Y1_PORT    = 3'd3;
    localparam logic [2:0] OUT_NONE       = 3'b111;

    localparam logic [2:0] SW_LOCAL = 3'd0;
    localparam logic [2:0] SW_X1    = 3'd1;
    localparam logic [2:0] SW_X2    = 3'd2;
    localparam logic [2:0] SW_Y1    = 3'd3;
    localparam logic [2:0] SW_NONE  = 3'b111;

    // tag = {dst_y, dst_x[1:0]}; X is resolved before Y
    function automatic logic [2:0] xy_route(
        input logic [2:0] tag,
        input logic [1:0] my_x,
        input logic       my_y
    );
        logic [1:0] w_dx;
        logic       w_dy;
        w_dx = tag[1:0];
        w_dy = tag[2];
        if (w_dx > my_x)       return OUT_X1_PORT;
        else if (w_dx < my_x)  return OUT_X2_PORT;
        else if (w_dy != my_y) return OUT_Y1_PORT;
        else                   return OUT_LOCAL_PORT;
    endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// Synchronous flit FIFO with head and head+1 read ports so the
// requester can look one entry ahead for back-to-back grants.
module flit_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [FLIT_W-1:0] i_din,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_multi,
    output logic [FLIT_W-1:0] o_head,
    output logic [FLIT_W-1:0] o_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     w_rptr1;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_multi = (r_count >= CW'(2));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign w_rptr1 = r_rptr + AW'(1);
    assign o_head  = r_mem[r_rptr];
    assign o_next  = r_mem[w_rptr1];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= w_rptr1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input requester: buffers flits, XY-routes the head, requests the
// allocator and forwards on grant. Optional counters: IPU_STATS_EN.
module input_port_unit
    import input_port_unit_pkg::*;
#(
    parameter int         FLIT_W = 32,
    parameter int         DEPTH  = 4,
    parameter int         MY_X   = 0,
    parameter int         MY_Y   = 0,
    parameter logic [2:0] MY_SW  = SW_LOCAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic [2:0]        port_dst,
    input  logic [2:0]        out_local_sw,
    input  logic [2:0]        out_x1_sw,
    input  logic [2:0]        out_x2_sw,
    input  logic [2:0]        out_y_sw,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid
`ifdef IPU_STATS_EN
    ,
    output logic [15:0]       sent_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    logic              w_full;
    logic              w_empty;
    logic              w_multi;
    logic              w_push;
    logic              w_grant;
    logic [FLIT_W-1:0] w_head;
    logic [FLIT_W-1:0] w_next;
    logic [2:0]        w_sel;
    logic [2:0]        w_route_head;
    logic [2:0]        w_route_next;
    logic [2:0]        r_req;

    assign in_ready = rst_n && en && !w_full;
    assign w_push   = in_valid && in_ready;

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (in_flit),
        .i_pop   (w_grant),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_multi (w_multi),
        .o_head  (w_head),
        .o_next  (w_next)
    );

    assign w_route_head = xy_route(w_head[FLIT_W-1 -: 3], 2'(MY_X), 1'(MY_Y));
    assign w_route_next = xy_route(w_next[FLIT_W-1 -: 3], 2'(MY_X), 1'(MY_Y));

    always_comb begin
        w_sel = SW_NONE;
        case (r_req)
            OUT_LOCAL_PORT: w_sel = out_local_sw;
            OUT_X1_PORT:    w_sel = out_x1_sw;
            OUT_X2_PORT:    w_sel = out_x2_sw;
            OUT_Y1_PORT:    w_sel = out_y_sw;
            default:        w_sel = SW_NONE;
        endcase
    end

    assign w_grant = en && !w_empty && (r_req != OUT_NONE) && (w_sel == MY_SW);

    // On a grant the head leaves this cycle, so request for head+1 instead
    always_comb begin
        port_dst = OUT_NONE;
        if (en && !w_empty) begin
            if (w_grant) port_dst = w_multi ? w_route_next : OUT_NONE;
            else         port_dst = w_route_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_req <= OUT_NONE;
        else        r_req <= port_dst;
    end

    assign flit_out_valid = w_grant;
    assign flit_out       = w_grant ? w_head : '0;

`ifdef IPU_STATS_EN
    logic [15:0] r_sent;
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sent  <= '0;
            r_stall <= '0;
        end else if (w_grant) begin
            if (r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
        end else if (r_req != OUT_NONE) begin
            if (r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
        end
    end

    assign sent_cnt  = r_sent;
    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// Scoreboard bench for input_port_unit at MY_X=1, MY_Y=0, MY_SW=SW_X1.
// Counters are checked when built with IPU_STATS_EN.
module tb_input_port_unit;
    import input_port_unit_pkg::*;

    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_flit = '0;
    logic        in_ready;
    logic [2:0]  port_dst;
    logic [2:0]  out_local_sw = SW_NONE;
    logic [2:0]  out_x1_sw = SW_NONE;
    logic [2:0]  out_x2_sw = SW_NONE;
    logic [2:0]  out_y_sw = SW_NONE;
    logic [31:0] flit_out;
    logic        flit_out_valid;
`ifdef IPU_STATS_EN
    logic [15:0] sent_cnt;
    logic [15:0] stall_cnt;
    int          m_sent = 0;
    int          m_stall = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    logic [31:0] sbq[$];
    logic [2:0]  mreq = OUT_NONE;

    always #5 clk = ~clk;

    input_port_unit #(
        .FLIT_W (32),
        .DEPTH  (DP),
        .MY_X   (1),
        .MY_Y   (0),
        .MY_SW  (SW_X1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .in_valid       (in_valid),
        .in_flit        (in_flit),
        .in_ready       (in_ready),
        .port_dst       (port_dst),
        .out_local_sw   (out_local_sw),
        .out_x1_sw      (out_x1_sw),
        .out_x2_sw      (out_x2_sw),
        .out_y_sw       (out_y_sw),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid)
`ifdef IPU_STATS_EN
        ,
        .sent_cnt       (sent_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    // Router sits at column 1, row 0
    function automatic logic [2:0] mroute(input logic [31:0] f);
        int dx;
        int dy;
        dx = int'(f[30:29]);
        dy = int'(f[31]);
        if (dx > 1) return OUT_X1_PORT;
        if (dx < 1) return OUT_X2_PORT;
        if (dy != 0) return OUT_Y1_PORT;
        return OUT_LOCAL_PORT;
    endfunction

    function automatic logic [2:0] rsw();
        case ($urandom_range(0, 4))
            0:       return SW_LOCAL;
            1:       return SW_X1;
            2:       return SW_X2;
            3:       return SW_Y1;
            default: return SW_NONE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every forwarded flit must be the oldest accepted one
    always @(negedge clk) begin
        if (rst_n) begin
            if (flit_out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_out: got %h expected nothing queued", flit_out);
                end else begin
                    chk("flit_out", flit_out, sbq.pop_front());
                end
            end else begin
                chk("flit_out_idle", flit_out, 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_port_dst", 32'(port_dst), 32'(OUT_NONE));
        chk("rst_valid", 32'(flit_out_valid), 32'h0);
        chk("rst_flit", flit_out, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
`ifdef IPU_STATS_EN
        chk("rst_sent", 32'(sent_cnt), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        m_sent = 0;
        m_stall = 0;
`endif
        mq.delete();
        sbq.delete();
        mreq = OUT_NONE;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge
    task automatic cycle(
        input logic        v,
        input logic [31:0] f,
        input logic        e,
        input logic [2:0]  sl,
        input logic [2:0]  sx1,
        input logic [2:0]  sx2,
        input logic [2:0]  sy
    );
        logic [2:0] sel;
        logic [2:0] eport;
        logic       egr;
        logic       erdy;
        in_valid = v;
        in_flit = f;
        en = e;
        out_local_sw = sl;
        out_x1_sw = sx1;
        out_x2_sw = sx2;
        out_y_sw = sy;
        @(negedge clk);
        case (mreq)
            OUT_LOCAL_PORT: sel = sl;
            OUT_X1_PORT:    sel = sx1;
            OUT_X2_PORT:    sel = sx2;
            OUT_Y1_PORT:    sel = sy;
            default:        sel = SW_NONE;
        endcase
        egr = e && (mreq != OUT_NONE) && (sel == SW_X1);
        erdy = e && (mq.size() < DP);
        if (!e || mq.size() == 0) eport = OUT_NONE;
        else if (egr) eport = (mq.size() >= 2) ? mroute(mq[1]) : OUT_NONE;
        else eport = mroute(mq[0]);
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("flit_out_valid", 32'(flit_out_valid), 32'(egr));
        chk("port_dst", 32'(port_dst), 32'(eport));
`ifdef IPU_STATS_EN
        chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        @(posedge clk);
        if (egr) void'(mq.pop_front());
        if (v && erdy) begin
            mq.push_back(f);
            sbq.push_back(f);
        end
        mreq = eport;
`ifdef IPU_STATS_EN
        if (egr) begin
            if (m_sent < 65535) m_sent++;
        end else if (eport == eport && mreq_prev_pending(sel, egr)) begin
            if (m_stall < 65535) m_stall++;
        end
`endif
        #1;
    endtask

`ifdef IPU_STATS_EN
    logic [2:0] stall_req = OUT_NONE;
    function automatic logic mreq_prev_pending(input logic [2:0] s, input logic g);
        return (stall_req != OUT_NONE) && !g && (s == s);
    endfunction
    always @(negedge clk) stall_req = mreq;
`endif

    initial begin
        #1;
        do_reset();

        // Routing: each head in turn, then drained back to back
        cycle(1, 32'h2000_0011, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(1, 32'h6000_00AA, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(1, 32'h8000_0022, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(1, 32'hA000_0033, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        for (int i = 0; i < 6; i++)
            cycle(0, 32'h0, 1, SW_X1, SW_X1, SW_X1, SW_X1);

        // Single grant and pop
        cycle(1, 32'h6000_00AA, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);

        // Back-to-back to X1
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h6000_0100 + 32'(i), 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);
        for (int i = 0; i < 4; i++)
            cycle(0, 32'h0, 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);

        // Contention: X1 output given to Y1 for a while
        do_reset();
        cycle(1, 32'h6000_0001, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        for (int i = 0; i < 6; i++)
            cycle(0, 32'h0, 1, SW_NONE, SW_Y1, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);
`ifdef IPU_STATS_EN
        chk("contention_stall", 32'(stall_cnt), 32'd5);
        chk("contention_sent", 32'(sent_cnt), 32'd1);
`endif

        // Enable low freezes everything and ignores grants
        cycle(1, 32'hE000_0005, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_X1, SW_X1, SW_X1, SW_X1);
        cycle(1, 32'h6000_0006, 0, SW_X1, SW_X1, SW_X1, SW_X1);
        cycle(1, 32'h6000_0007, 0, SW_X1, SW_X1, SW_X1, SW_X1);
        for (int i = 0; i < 3; i++)
            cycle(0, 32'h0, 1, SW_X1, SW_X1, SW_X1, SW_X1);

        // Full, then reset in the middle of a grant
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h6000_0200 + 32'(i), 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(1, 32'h6000_02FF, 1, SW_NONE, SW_NONE, SW_NONE, SW_NONE);
        cycle(0, 32'h0, 1, SW_NONE, SW_X1, SW_NONE, SW_NONE);
        do_reset();
        cycle(0, 32'h0, 1, SW_X1, SW_X1, SW_X1, SW_X1);
        cycle(0, 32'h0, 1, SW_X1, SW_X1, SW_X1, SW_X1);

        // Randomized traffic with grants biased towards the pending request
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] s [4];
            for (int k = 0; k < 4; k++) s[k] = rsw();
            if (mreq != OUT_NONE && $urandom_range(0, 9) < 6) s[mreq[1:0]] = SW_X1;
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) != 0),
                  s[0], s[1], s[2], s[3]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
